// File: rtl/div_low_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_low_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width for an n-step operation; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_low_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_low_step #(
  parameter int M = 4
) (
  input  logic [M:0]   pr_i,
  input  logic         bit_i,
  input  logic [M-1:0] divisor_i,
  output logic [M:0]   pr_o,
  output logic         q_o
);

  logic [M:0] shifted;
  logic       pr_msb_unused;

  // The incoming pr is already below the divisor, so its MSB is always zero and drops out.
  assign pr_msb_unused = pr_i[M];
  assign shifted       = {pr_i[M-1:0], bit_i};
  assign q_o           = (shifted >= {1'b0, divisor_i});
  assign pr_o          = q_o ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/div_low.sv
// Non-pipelined restoring divider: N-bit dividend / M-bit divisor, one quotient bit per clock.
import div_low_pkg::*;

module div_low #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         res_rdy,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [M-1:0]    dvsr_q, dvsr_d;
  logic [M:0]      pr_q, pr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [M-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [M:0]      step_pr;
  logic            step_q;

  div_low_step #(.M(M)) u_step (
    .pr_i      (pr_q),
    .bit_i     (shift_q[N-1]),
    .divisor_i (dvsr_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      dvsr_q  <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Quotient bits enter the shifter LSB as dividend bits leave its MSB.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (data_rdy) begin
          shift_d = dividend;
          dvsr_d  = divisor;
          pr_d    = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        pr_d    = step_pr;
        shift_d = {shift_q[N-2:0], step_q};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quot_d  = {shift_q[N-2:0], step_q};
          rem_d   = step_pr[M-1:0];
          dz_d    = (dvsr_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign res_rdy   = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
